pipe_stage_elastic: RTL and testbench

- Parametrised, generic inter-stage pipeline register. It replaces the hand-written per-stage latches (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with one elastic block.
- Carries an opaque DATA_W payload bundle (control ops, operands, immediates, register addresses) under a valid/ready handshake.
- Supports stall (pause), flush with NOP bubble insertion, and an optional 2-entry skid buffer that breaks the ready path.
- Includes saturating bubble and stall performance counters for pipeline tuning.

---
 rtl/pipe_stage_elastic.sv | 112 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with flush, pause,
// optional 2-entry skid buffer and saturating perf counters.
module pipe_stage_elastic #(
   parameter int                DATA_W    = 128,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter int                SKID      = 1,
   parameter int                CNT_W     = 16
) (
   input  logic              clk_50MHz,
   input  logic              rst,
   input  logic              pause,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_fire, out_fire;

   assign out_valid = (state_q != EMPTY) & ~pause;
   // With a skid entry, in_ready comes from registered state only
   assign in_ready  = (SKID != 0)
                    ? (state_q != TWO) & ~pause
                    : ~pause & ((state_q == EMPTY) | out_ready);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else if (!pause) begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               unique case (1'b1)
                  in_fire & out_fire: begin
                     main_d = in_data;
                  end
                  in_fire & ~out_fire: begin
                     state_d = TWO;
                     skid_d  = in_data;
                  end
                  ~in_fire & out_fire: begin
                     state_d = EMPTY;
                     main_d  = NOP_VALUE;
                  end
                  default: ;
               endcase
            end
            TWO: begin
               if (out_fire) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_VALUE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = NOP_VALUE;
               skid_d  = NOP_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (!rst) begin
         state_q    <= EMPTY;
         main_q     <= NOP_VALUE;
         skid_q     <= NOP_VALUE;
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         if (!out_valid && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + CNT_ONE;
         if (out_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue scoreboard plus
// a narrow CNT_W=4 instance kept idle for counter saturation.
module tb_pipe_stage_elastic;

   localparam logic [127:0] NOP = '0;

   logic         clk_50MHz = 1'b0;
   logic         rst = 1'b0;
   logic         pause = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;
   logic [15:0]  bubble_cnt;
   logic [15:0]  stall_cnt;

   logic         s_in_valid = 1'b0;
   logic         s_in_ready;
   logic [7:0]   s_in_data = 8'h00;
   logic         s_out_valid;
   logic         s_out_ready = 1'b0;
   logic [7:0]   s_out_data;
   logic [3:0]   s_bubble_cnt;
   logic [3:0]   s_stall_cnt;

   pipe_stage_elastic u_dut (
      .clk_50MHz  (clk_50MHz),
      .rst        (rst),
      .pause      (pause),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .bubble_cnt (bubble_cnt),
      .stall_cnt  (stall_cnt)
   );

   pipe_stage_elastic #(
      .DATA_W    (8),
      .NOP_VALUE (8'h00),
      .SKID      (1),
      .CNT_W     (4)
   ) u_sat (
      .clk_50MHz  (clk_50MHz),
      .rst        (rst),
      .pause      (1'b0),
      .flush      (1'b0),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .in_data    (s_in_data),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .out_data   (s_out_data),
      .bubble_cnt (s_bubble_cnt),
      .stall_cnt  (s_stall_cnt)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   int           checks = 0;
   int           errors = 0;
   logic [127:0] q[$];
   logic [15:0]  m_bub, m_stall;
   logic [3:0]   m_sbub;
   logic         e_ov, e_ir, acc;
   logic [127:0] e_od;
   logic [127:0] src[8];

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_bub   = '0;
      m_stall = '0;
      m_sbub  = '0;
   endtask

   task automatic do_reset(input int edges);
      rst = 1'b0;
      in_valid = 1'b1;
      in_data = 128'hA5;
      repeat (edges) @(posedge clk_50MHz);
      #1;
      model_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
   endtask

   task automatic step();
      @(negedge clk_50MHz);
      e_ov = (q.size() != 0) && !pause;
      e_ir = (q.size() < 2) && !pause;
      e_od = (q.size() != 0) ? q[0] : NOP;
      chk("out_valid", out_valid, e_ov);
      chk("in_ready", in_ready, e_ir);
      chk("out_data", out_data, e_od);
      chk("bubble_cnt", bubble_cnt, m_bub);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("sat_bubble", s_bubble_cnt, m_sbub);
      chk("sat_stall", s_stall_cnt, 4'd0);
      @(posedge clk_50MHz);
      acc = in_valid && e_ir;
      if (!e_ov && m_bub != 16'hFFFF) m_bub++;
      if (e_ov && !out_ready && m_stall != 16'hFFFF) m_stall++;
      if (m_sbub != 4'hF) m_sbub++;
      if (flush) begin
         q.delete();
      end else if (!pause) begin
         if (e_ov && out_ready) void'(q.pop_front());
         if (acc) q.push_back(in_data);
      end
      #1;
   endtask

   task automatic fill_src();
      for (int i = 0; i < 8; i++)
         src[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic burst(input int n, input int hold);
      int idx = 0;
      int cyc = 0;
      while ((idx < n || q.size() != 0) && cyc < 64) begin
         out_ready = (cyc >= hold);
         in_valid  = (idx < n);
         in_data   = (idx < n) ? src[idx] : '0;
         step();
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      chk("burst_timeout", cyc < 64, 1'b1);
   endtask

   initial begin
      model_reset();
      do_reset(2);
      step();

      fill_src();
      burst(8, 0);

      fill_src();
      burst(3, 5);

      fill_src();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = src[0];
      step();
      in_data   = src[1];
      step();
      flush     = 1'b1;
      in_data   = src[2];
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      step();
      src[0] = src[3];
      burst(1, 0);

      fill_src();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = src[5];
      step();
      pause     = 1'b1;
      out_ready = 1'b1;
      in_data   = src[6];
      repeat (3) step();
      pause     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      step();
      step();

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = src[7];
      step();
      do_reset(1);
      out_ready = 1'b1;
      repeat (20) step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
